// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the requesters, the TX arbiter and the UART TX FIFO.
// The arbiter connects through the slave modport; the requester/FIFO side
// (or a testbench standing in for it) uses the master modport.
interface uart_tx_arbiter_if #(
    parameter int DataLength    = 8,
    parameter int NumRequesters = 4
);
    logic [NumRequesters-1:0]            i_req;
    logic [NumRequesters*DataLength-1:0] i_data;
    logic [NumRequesters-1:0]            i_last;
    logic [NumRequesters-1:0]            o_ack;
    logic [DataLength-1:0]               o_tx_data;
    logic                                o_tx_req;
    logic                                i_tx_full;

    modport slave (
        input  i_req,
        input  i_data,
        input  i_last,
        input  i_tx_full,
        output o_ack,
        output o_tx_data,
        output o_tx_req
    );

    modport master (
        output i_req,
        output i_data,
        output i_last,
        output i_tx_full,
        input  o_ack,
        input  o_tx_data,
        input  o_tx_req
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter in front of the UART TX FIFO.
// Optional stall timeout is built only when UART_ARB_TIMEOUT_EN is defined;
// otherwise o_timeout is tied low and a stalled owner keeps the grant.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no owner; pick first requester at/after rr (one dead cycle)
// ST_SEND | owner's bytes forwarded to the FIFO until its last byte
module uart_tx_arbiter #(
    parameter int DataLength    = 8,
    parameter int NumRequesters = 4,
    parameter int TimeoutCycles = 1024
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    uart_tx_arbiter_if.slave                 bus,
    output logic [$clog2(NumRequesters)-1:0] o_owner,
    output logic                             o_busy,
    output logic                             o_timeout
);
    localparam int OwnerW = $clog2(NumRequesters);

    if (NumRequesters < 2 || TimeoutCycles < 1) begin : g_param_check
        $error("uart_tx_arbiter: needs NumRequesters >= 2 and TimeoutCycles >= 1");
    end

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [OwnerW-1:0]   r_owner;
    logic [OwnerW-1:0]   w_owner_nxt;
    logic [OwnerW-1:0]   r_rr;
    logic [OwnerW-1:0]   w_rr_nxt;
    logic [OwnerW-1:0]   w_owner_inc;
    logic [OwnerW-1:0]   w_pick;
    logic [OwnerW:0]     w_off;
    logic [OwnerW:0]     w_sum;
    logic [NumRequesters-1:0] w_rot;
    logic                w_any;
    logic                w_owner_req;
    logic                w_owner_last;
    logic                w_xfer;
    logic                w_timeout_hit;

    assign w_any        = |bus.i_req;
    assign w_owner_req  = bus.i_req[r_owner];
    assign w_owner_last = bus.i_last[r_owner];
    assign w_xfer       = (r_state == ST_SEND) && w_owner_req && !bus.i_tx_full;

    // Rotate requests so bit 0 is the requester at rr, then take the lowest set bit.
    assign w_rot = NumRequesters'({bus.i_req, bus.i_req} >> r_rr);

    // Round-robin winner: first requester at or after rr, wrapping modulo N.
    always_comb begin
        w_off = '0;
        for (int j = NumRequesters - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_off = (OwnerW + 1)'(j);
            end
        end
        w_sum = {1'b0, r_rr} + w_off;
        if (w_sum >= (OwnerW + 1)'(NumRequesters)) begin
            w_pick = OwnerW'(w_sum - (OwnerW + 1)'(NumRequesters));
        end else begin
            w_pick = w_sum[OwnerW-1:0];
        end
    end

    // Pointer to the requester after the current owner; N-1 wraps to 0.
    always_comb begin
        if (r_owner == OwnerW'(NumRequesters - 1)) begin
            w_owner_inc = '0;
        end else begin
            w_owner_inc = r_owner + 1'b1;
        end
    end

    // Next-state logic: grant in IDLE, release on last byte or timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_rr_nxt    = r_rr;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_owner_nxt = w_pick;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if ((w_xfer && w_owner_last) || w_timeout_hit) begin
                    w_state_nxt = ST_IDLE;
                    w_rr_nxt    = w_owner_inc;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State, owner and round-robin pointer registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_owner <= '0;
            r_rr    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_rr    <= w_rr_nxt;
        end
    end

    // Transfer outputs are combinational so a byte moves in the cycle it is offered.
    always_comb begin
        bus.o_ack     = '0;
        bus.o_tx_req  = 1'b0;
        bus.o_tx_data = '0;
        if (w_xfer) begin
            bus.o_ack[r_owner] = 1'b1;
            bus.o_tx_req       = 1'b1;
            bus.o_tx_data      = bus.i_data[r_owner*DataLength +: DataLength];
        end
    end

    assign o_owner = r_owner;
    assign o_busy  = (r_state == ST_SEND);

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CntW = $clog2(TimeoutCycles + 1);

    logic [CntW-1:0] r_stall_cnt;
    logic            r_timeout;

    // Only an owner that withdrew its request counts; FIFO-full stalls with req high clear it.
    assign w_timeout_hit = (r_state == ST_SEND) && !w_owner_req &&
                           (r_stall_cnt == CntW'(TimeoutCycles - 1));

    // Stall counter and one-cycle timeout pulse, aligned with the return to IDLE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cnt <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_timeout <= w_timeout_hit;
            if ((r_state != ST_SEND) || w_owner_req || w_timeout_hit) begin
                r_stall_cnt <= '0;
            end else begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign o_timeout = r_timeout;
`else
    assign w_timeout_hit = 1'b0;
    assign o_timeout     = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: round-robin order, wrap, backpressure,
// packet atomicity, mid-packet reset and the stall timeout (both builds).
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int DL = 8;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic [1:0] o_owner;
    logic       o_busy;
    logic       o_timeout;

    uart_tx_arbiter_if #(.DataLength(DL), .NumRequesters(N)) bus();

    uart_tx_arbiter #(
        .DataLength(DL),
        .NumRequesters(N),
        .TimeoutCycles(16)
    ) dut (
        .i_clk(i_clk),
        .i_rst_n(i_rst_n),
        .bus(bus),
        .o_owner(o_owner),
        .o_busy(o_busy),
        .o_timeout(o_timeout)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;

    // requester models
    bit         act  [N];
    bit         drop [N];
    int         idx  [N];
    int         len  [N];
    logic [7:0] base [N];

    // outputs sampled mid-cycle
    logic [N-1:0] s_ack;
    logic         s_req;
    logic [7:0]   s_data;
    logic [1:0]   s_owner;
    logic         s_busy;
    logic         s_to;

    logic [7:0] rr_data [12] = '{8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22,
                                 8'h30, 8'h31, 8'h32, 8'h40, 8'h41, 8'h42};
    int         rr_cyc  [12] = '{1, 2, 3, 5, 6, 7, 9, 10, 11, 13, 14, 15};
    logic [7:0] rst_exp [4]  = '{8'h61, 8'h62, 8'h63, 8'h80};
    logic [7:0] log_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int n = 0; n < N; n++) begin
            bus.i_req[n]           = act[n] && !drop[n];
            bus.i_last[n]          = act[n] && (idx[n] == len[n] - 1);
            bus.i_data[n*DL +: DL] = act[n] ? base[n] + 8'(idx[n]) : 8'h00;
        end
    endtask

    task automatic start(input int n, input int l, input logic [7:0] b);
        act[n]  = 1'b1;
        idx[n]  = 0;
        len[n]  = l;
        base[n] = b;
    endtask

    // Sample one cycle at the falling edge, advance acked requesters, drive next cycle.
    task automatic cyc();
        @(negedge i_clk);
        s_ack   = bus.o_ack;
        s_req   = bus.o_tx_req;
        s_data  = bus.o_tx_data;
        s_owner = o_owner;
        s_busy  = o_busy;
        s_to    = o_timeout;
        for (int n = 0; n < N; n++) begin
            if (s_ack[n] && act[n]) begin
                idx[n]++;
                if (idx[n] == len[n]) act[n] = 1'b0;
            end
        end
        @(posedge i_clk);
        #1;
        drive();
    endtask

    function automatic bit any_act();
        bit r = 1'b0;
        for (int n = 0; n < N; n++) r |= act[n];
        return r;
    endfunction

    // Drain all open packets within a cycle budget, logging every written byte.
    task automatic drain(input string tag);
        int budget = 0;
        log_q.delete();
        while (any_act() && budget < 40) begin
            cyc();
            if (s_req) log_q.push_back(s_data);
            budget++;
        end
        check(tag, 32'(any_act()), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int np;
        int a5cnt;
        i_rst_n       = 1'b0;
        bus.i_tx_full = 1'b0;
        for (int n = 0; n < N; n++) begin
            act[n] = 1'b0; drop[n] = 1'b0; idx[n] = 0; len[n] = 1; base[n] = 8'h00;
        end
        drive();
        repeat (2) @(posedge i_clk);
        #1;
        for (int n = 0; n < N; n++) start(n, 3, 8'(8'h10 * (n + 1)));
        drive();

        // reset values with all requests pending
        cyc();
        check("rst_ack",     32'(s_ack),   32'd0);
        check("rst_owner",   32'(s_owner), 32'd0);
        check("rst_busy",    32'(s_busy),  32'd0);
        check("rst_tx_data", 32'(s_data),  32'd0);
        check("rst_tx_req",  32'(s_req),   32'd0);
        check("rst_timeout", 32'(s_to),    32'd0);
        i_rst_n = 1'b1;

        // round-robin: four 3-byte packets, 12 pulses in a 19-cycle window
        np = 0;
        for (int c = 0; c < 19; c++) begin
            cyc();
            check("rr_busy", 32'(s_busy), 32'((c % 4 != 0) && (c < 16)));
            if (s_req) begin
                if (np < 12) begin
                    check("rr_data",  32'(s_data), 32'(rr_data[np]));
                    check("rr_cycle", c,           rr_cyc[np]);
                    check("rr_ack",   32'(s_ack),  32'd1 << (np / 3));
                end
                np++;
            end
        end
        check("rr_pulses", np, 12);

        // wrap-around: 0 and 3 both request, rr has wrapped to 0
        start(0, 1, 8'h10);
        start(3, 1, 8'h40);
        drive();
        cyc();
        check("wrap_arb_req", 32'(s_req), 32'd0);
        cyc();
        check("wrap_owner0", 32'(s_owner), 32'd0);
        check("wrap_data0",  32'(s_data),  32'h10);
        check("wrap_ack0",   32'(s_ack),   32'b0001);
        cyc();
        check("wrap_gap", 32'(s_req), 32'd0);
        cyc();
        check("wrap_owner3", 32'(s_owner), 32'd3);
        check("wrap_data3",  32'(s_data),  32'h40);

        // backpressure: 0xA5 pending while the FIFO is full for 5 cycles
        start(1, 3, 8'hA4);
        drive();
        cyc();
        cyc();
        check("bp_first", 32'(s_data), 32'hA4);
        bus.i_tx_full = 1'b1;
        a5cnt = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("bp_req",   32'(s_req),   32'd0);
            check("bp_ack",   32'(s_ack),   32'd0);
            check("bp_data",  32'(s_data),  32'd0);
            check("bp_owner", 32'(s_owner), 32'd1);
        end
        bus.i_tx_full = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (s_req && s_data == 8'hA5) a5cnt++;
            if (i == 0) begin
                check("bp_release_data", 32'(s_data), 32'hA5);
                check("bp_release_ack",  32'(s_ack),  32'b0010);
            end
        end
        check("bp_a5_once", a5cnt, 1);

        // atomicity: owner 1 withdraws mid-packet while 2 requests
        start(1, 4, 8'h50);
        drive();
        cyc();
        cyc();
        check("at_first", 32'(s_data), 32'h50);
        drop[1] = 1'b1;
        start(2, 1, 8'h30);
        drive();
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("at_owner", 32'(s_owner), 32'd1);
            check("at_ack",   32'(s_ack),   32'd0);
            check("at_busy",  32'(s_busy),  32'd1);
        end
        drop[1] = 1'b0;
        drive();
        for (int k = 1; k < 4; k++) begin
            cyc();
            check("at_resume", 32'(s_data), 32'(8'h50 + k));
        end
        cyc();
        check("at_gap", 32'(s_req), 32'd0);
        cyc();
        check("at_next_owner", 32'(s_owner), 32'd2);
        check("at_next_ack",   32'(s_ack),   32'b0100);

        // reset mid-packet: requester 2 sends byte 0 of 4, then reset
        start(2, 4, 8'h60);
        drive();
        cyc();
        cyc();
        check("mr_byte0", 32'(s_data), 32'h60);
        i_rst_n = 1'b0;
        start(1, 1, 8'h70);
        start(3, 1, 8'h80);
        drive();
        for (int i = 0; i < 2; i++) begin
            cyc();
            check("mr_req",   32'(s_req),   32'd0);
            check("mr_ack",   32'(s_ack),   32'd0);
            check("mr_data",  32'(s_data),  32'd0);
            check("mr_owner", 32'(s_owner), 32'd0);
            check("mr_busy",  32'(s_busy),  32'd0);
        end
        i_rst_n = 1'b1;
        cyc();
        check("mr_arb", 32'(s_req), 32'd0);
        cyc();
        check("mr_owner1", 32'(s_owner), 32'd1);
        check("mr_data1",  32'(s_data),  32'h70);
        drain("mr_drain");
        check("mr_log_len", log_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < log_q.size()) check("mr_log", 32'(log_q[i]), 32'(rst_exp[i]));
        end

        // stalled owner 2 with requester 3 waiting
        start(2, 3, 8'h90);
        drive();
        cyc();
        cyc();
        check("to_first", 32'(s_data), 32'h90);
        drop[2] = 1'b1;
        start(3, 1, 8'hB0);
        drive();
        for (int i = 1; i <= 20; i++) begin
            cyc();
`ifdef UART_ARB_TIMEOUT_EN
            check("to_pulse", 32'(s_to), 32'(i == 17));
            if (i <= 16) begin
                check("to_hold_owner", 32'(s_owner), 32'd2);
                check("to_hold_ack",   32'(s_ack),   32'd0);
            end
            if (i == 18) begin
                check("to_next_owner", 32'(s_owner), 32'd3);
                check("to_next_data",  32'(s_data),  32'hB0);
                check("to_next_req",   32'(s_req),   32'd1);
            end
`else
            check("to_none",  32'(s_to),    32'd0);
            check("to_owner", 32'(s_owner), 32'd2);
            check("to_ack",   32'(s_ack),   32'd0);
`endif
        end
        drop[2] = 1'b0;
        drive();
        drain("to_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Packet-atomic round-robin arbiter that shares the single transmit path of the `uart` block between several on-chip requesters. Each requester offers bytes through a valid/ack handshake and marks the final byte of its packet. The arbiter forwards the current owner's bytes into the UART TX FIFO through `o_tx_req`/`o_tx_data`, honouring FIFO backpressure. It sits between the requester logic and the `uart` instance's `i_tx_data`/`i_tx_req` ports, with `i_tx_full` derived from `o_status`.

## Interface
- `DataLength`, 8, byte width; must match the `uart` instance.
- `NumRequesters`, 4, number of requesters N; N ≥ 2.
- `TimeoutCycles`, 1024, stall limit; used only with `UART_ARB_TIMEOUT_EN`; must be ≥ 1.
- `i_clk` in 1, system clock, rising edge.
- `i_rst_n` in 1, asynchronous active-low reset.
- `i_req` in N, requester n holds a valid byte.
- `i_data` in N*DataLength, byte of requester n in slice [n*DataLength +: DataLength].
- `i_last` in N, byte of requester n is the last byte of its packet.
- `o_ack` out N, one-hot; byte of requester n is accepted this cycle.
- `o_owner` out $clog2(N), index of the current owner; holds its last value in IDLE.
- `o_busy` out 1, high while in SEND.
- `o_tx_data` out DataLength, byte to the UART TX FIFO.
- `o_tx_req` out 1, single-cycle write strobe into the UART TX FIFO.
- `i_tx_full` in 1, TX FIFO has zero free entries this cycle; must be same-cycle accurate.
- `o_timeout` out 1, single-cycle pulse when a stalled owner is revoked.

## Operation
- FSM has two states: IDLE and SEND. Reset enters IDLE with round-robin pointer `rr` = 0.
- **IDLE:** if any `i_req` bit is set, select the first requester at or after `rr`, wrapping modulo N.
  - Register the winner as owner and go to SEND.
  - No byte is transferred in the arbitration cycle.
- **SEND:** `xfer` = `i_req[owner]` & ~`i_tx_full`. While `xfer` is high:
  - `o_ack[owner]` = 1.
  - `o_tx_req` = 1.
  - `o_tx_data` = `i_data[owner]`.
- These three outputs are combinational from the registered owner and the live inputs. All other `o_ack` bits are 0.
- **End of packet:** when `xfer` and `i_last[owner]` are both high, go to IDLE and set `rr` = (owner+1) mod N. N−1 wraps to 0.
- **Grant is packet-atomic.** When the owner drops `i_req` mid-packet, it keeps the grant. Other requesters wait.
- **Requester rule:** hold `i_req`, `i_data` and `i_last` stable until acked. The byte changes only on the cycle after an ack.
- **Backpressure:** while `i_tx_full` is high, `o_tx_req` = 0 and `o_ack` = 0. State and owner are held.
- A single-byte packet (`i_last` on the first byte) takes one SEND cycle.
- Requests on non-owners have no effect on the current packet. They are considered at the next IDLE.
- Reset asserted mid-packet aborts immediately: IDLE, `rr` = 0, every output 0. No partial byte is written to the FIFO.

## Timing
- Reset values:
  - `o_ack` = 0, `o_owner` = 0, `o_busy` = 0.
  - `o_tx_data` = 0, `o_tx_req` = 0, `o_timeout` = 0.
- `o_tx_data` is 0 whenever `o_tx_req` = 0.
- Latency from `i_req` rising in IDLE to the first `o_tx_req`: 2 cycles (arbitration edge, then transfer cycle).
- A K-byte packet with no backpressure occupies 1 + K cycles.
- Back-to-back packets are separated by exactly one IDLE cycle.
- `o_busy` rises on the edge that enters SEND and falls on the edge after the last byte's transfer.

## Configuration
- Macro: `UART_ARB_TIMEOUT_EN`.
- **Defined:**
  - A counter counts consecutive SEND cycles with `i_req[owner]` = 0. It clears on any cycle with `i_req[owner]` = 1.
  - Cycles stalled only by `i_tx_full` do not count.
  - When the count reaches `TimeoutCycles`: `o_timeout` pulses for 1 cycle, the FSM goes to IDLE, `rr` = owner+1, and the counter clears.
- **Undefined:** no counter is built, `o_timeout` is tied 0, and the grant is held indefinitely.

## Test plan
- **Round-robin:** N=4, all four requesters each offer a 3-byte packet from reset.
  - Packets appear on `o_tx_data` in order 0,1,2,3.
  - Each packet is contiguous, with one idle cycle between packets.
  - 12 `o_tx_req` pulses in 19 cycles.
- **Wrap-around:** after requester 3 finishes, requesters 0 and 3 both request.
  - Requester 0 wins (`rr` wrapped to 0).
  - A further request from 3 is served next.
- **Backpressure:** hold `i_tx_full` = 1 for 5 cycles mid-packet (byte 0xA5 pending).
  - No `o_tx_req` or `o_ack` during the stall.
  - 0xA5 is written exactly once after release.
- **Atomicity:** owner 1 drops `i_req` for 10 cycles mid-packet while requester 2 requests.
  - No grant change and no `o_ack[2]`.
  - Owner 1 resumes and completes its packet.
- **Reset mid-packet:** pulse `i_rst_n` low during byte 2 of 4.
  - All outputs read 0 while low.
  - After release, arbitration restarts from requester 0.
- **Timeout** (with `UART_ARB_TIMEOUT_EN`, `TimeoutCycles` = 16): owner 2 stalls.
  - `o_timeout` pulses after 16 idle-request cycles.
  - Requester 3 is granted next.
  - With the macro undefined, no timeout and no grant change.
